// File: rtl/rr_mux_select_if.sv
// rtl/rr_mux_select_if.sv - request/grant and mux-select bundle for rr_mux_select
interface rr_mux_select_if;
    logic [3:0] req;
    logic       done;
    logic       s0;
    logic       s1;
    logic       valid;
    logic [3:0] grant;
    logic       timeout;

    modport master (
        output req, done,
        input  s0, s1, valid, grant, timeout
    );

    modport slave (
        input  req, done,
        output s0, s1, valid, grant, timeout
    );
endinterface

// File: rtl/rr_mux_select.sv
// rtl/rr_mux_select.sv - round-robin 4-way arbiter driving 4:1 mux selects
// Optional dwell timer: define DWELL_TIMER_EN to force release after DWELL_MAX cycles.
module rr_mux_select #(
    parameter int DWELL_MAX = 15,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    rr_mux_select_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;
    logic        release_n;
    logic        expired;

    // Round-robin search starting one past the previous owner, wrapping mod 4.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign release_n = bus.done || !bus.req[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            GRANT: begin
                if (release_n || expired)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign bus.valid = (state_q == GRANT);
    assign bus.grant = grant_q;
    assign bus.s0    = owner_q[0];
    assign bus.s1    = owner_q[1];

`ifdef DWELL_TIMER_EN
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign expired = (state_q == GRANT) && (cnt_q == DWELL_LAST);

    // Counter rests at zero in IDLE so every grant starts a fresh dwell window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
            timeout_q <= expired && !release_n;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (DWELL_MAX > CNT_W);
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/rr_mux_select.md
RR_MUX_SELECT -- requirements
Module: rr_mux_select

Interface
REQ-001 Parameter: DWELL_MAX, default 15, max grant length in cycles when the dwell timer is compiled in; legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, dwell counter width; DWELL_MAX SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-channel request; req[i] for mux data input i (0=a, 1=b, 2=c, 3=d).
REQ-006 done  input  1  current owner finished; releases grant.
REQ-007 s0  output  1  mux select LSB, registered.
REQ-008 s1  output  1  mux select MSB, registered.
REQ-009 valid  output  1  a grant is active; selects are meaningful.
REQ-010 grant  output  4  one-hot owner, registered; all zero when valid=0.
REQ-011 timeout  output  1  one-cycle pulse on dwell-forced release.

Function
REQ-012 The block SHALL have two states, IDLE and GRANT, and drive the selects of a downstream 4-to-1 mux.
REQ-013 Selects SHALL encode owner index i as {s1,s0} = i (0->00, 1->01, 2->10, 3->11).
REQ-014 In IDLE with req != 0 at edge n, it SHALL enter GRANT with valid=1, grant and selects valid from cycle n+1 (1-cycle latency).
REQ-015 Arbitration SHALL be round-robin: search starts at (last+1) mod 4 and wraps; the first set req bit wins.
REQ-016 last SHALL update to the new owner index on every grant.
REQ-017 In IDLE with req == 0, the block SHALL stay in IDLE with valid=0, grant=0; s1/s0 hold their previous value.
REQ-018 In GRANT, the block SHALL release when done=1 or req[owner]=0; done and request-drop in the same cycle SHALL count as one release.
REQ-019 On release at edge n, valid=0 and grant=0 from cycle n+1; the state SHALL be IDLE for exactly one cycle, with re-arbitration on the next edge.
REQ-020 In GRANT, changes on non-owner req bits SHALL NOT affect the grant.
REQ-021 The output grant SHALL never have more than one bit set.
REQ-022 A channel requesting continuously SHALL wait at most three other grants before being served.

Reset
REQ-023 rst sampled high SHALL, on that edge, force IDLE, valid=0, grant=4'b0000, s0=0, s1=0, timeout=0, dwell counter=0, last=3 (channel 0 has first priority).
REQ-024 rst SHALL take precedence over all inputs, including mid-GRANT; no release pulse or timeout SHALL be generated by reset.
REQ-025 After rst deasserts, the first arbitration SHALL occur on the first edge with rst=0.

Configuration
REQ-026 Macro DWELL_TIMER_EN defined: the counter SHALL clear on grant and increment each GRANT cycle.
REQ-027 Macro DWELL_TIMER_EN defined: when the owner has held valid for DWELL_MAX cycles without another release, a forced release SHALL occur and timeout SHALL pulse high for one cycle, coincident with valid dropping.
REQ-028 Macro DWELL_TIMER_EN defined: if done or a request-drop coincides with expiry, the release SHALL be normal and timeout SHALL stay 0.
REQ-029 Macro DWELL_TIMER_EN undefined: no counter SHALL be built, timeout SHALL be tied 0, and grants SHALL last until done or request-drop.

Verification
REQ-030 Reset then req=4'b1111 held -> grants in order 0,1,2,3,0 with {s1,s0}=00,01,10,11,00, each separated by one valid=0 cycle when done pulses.
REQ-031 req=4'b0100 rises at edge n -> valid=1, grant=4'b0100, {s1,s0}=10 at n+1; req[2] drops at edge m -> valid=0 at m+1.
REQ-032 Owner 1 with done=1 and req[1]=0 in the same cycle -> single release, one IDLE cycle, then channel 2 granted if req[2]=1.
REQ-033 rst=1 mid-GRANT on channel 3 -> next cycle valid=0, grant=0, {s1,s0}=00; with req=4'b1001 after reset, channel 0 granted first.
REQ-034 DWELL_TIMER_EN with DWELL_MAX=4, req[0] held, done=0 -> valid high for exactly 4 cycles, timeout=1 on the fifth cycle, then channel 0 re-granted after one IDLE cycle.
REQ-035 DWELL_TIMER_EN undefined, same stimulus as REQ-034 -> grant held for 100 cycles and timeout stays 0.
